// File: rtl/arm_fetch_stage.sv
// arm_fetch_stage: instruction-fetch stage of the 32-bit ARM pipeline.
// Owns the program counter, addresses the combinational instruction memory
// and captures the returned word into the IF/ID pipeline register.
// Edge priority: reset (rst==0) > branch redirect > freeze > normal advance.
//
// Flow control: there is no valid/ready handshake on this block. imem_data is
// expected to be valid in the same cycle that imem_addr is presented.
// if_valid qualifies if_inst/if_pc; a 0 marks a bubble, which decode must
// ignore. freeze is the only back-pressure: while it is high, the PC, IF/ID
// and fetch_count all hold.
module arm_fetch_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] imem_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst,
  output logic              if_valid,
  output logic [31:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q,      pc_d;
  logic [ADDR_W-1:0] if_pc_q,   if_pc_d;
  logic [ADDR_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       count_q,   count_d;
  logic [ADDR_W-1:0] pc_plus_step;
  logic [ADDR_W-1:0] branch_target;

  // The next sequential PC wraps modulo 2^ADDR_W; the branch target's low
  // two bits are dropped so every fetch stays word aligned.
  assign pc_plus_step  = pc_q + STEP;
  assign branch_target = {branch_addr[ADDR_W-1:2], 2'b00};

  // Next-state selection for the PC, IF/ID register and fetch counter.
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;
    if (branch_taken) begin
      // Redirect; the word fetched this cycle is wrong-path and is dropped.
      pc_d       = branch_target;
      if_pc_d    = '0;
      if_inst_d  = '0;
      if_valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d       = pc_plus_step;
      if_pc_d    = pc_plus_step;
      if_inst_d  = imem_data;
      if_valid_d = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_arm_fetch_stage.sv
// tb_arm_fetch_stage: directed scenarios plus randomized stimulus for the
// fetch stage, compared every cycle against a behavioural model of the PC,
// IF/ID register and fetch counter.
module tb_arm_fetch_stage;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          freeze = 1'b0;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_addr = '0;
  logic [W-1:0]  imem_addr;
  logic [W-1:0]  imem_data;
  logic [W-1:0]  if_pc;
  logic [W-1:0]  if_inst;
  logic          if_valid;
  logic [31:0]   fetch_count;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents: the upper half is the inverted low address
  // half, so mem[0]=FFFF0000, mem[0x10]=FFEF0010, and so on.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  arm_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .fetch_count  (fetch_count)
  );

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  // The model follows the stage as a sequence of fetch events: each edge
  // either resets, redirects (bubble), holds, or accepts the word at the
  // current PC. Outputs are compared 1 time unit after every edge.
  logic [W-1:0] m_pc, m_if_pc, m_inst;
  logic         m_valid;
  logic [31:0]  m_cnt;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = 0; m_if_pc = 0; m_inst = 0; m_valid = 0; m_cnt = 0;
      chk_en = 1'b1;
    end else if (branch_taken) begin
      m_pc = branch_addr & ~32'd3;
      m_if_pc = 0; m_inst = 0; m_valid = 0;
    end else if (!freeze) begin
      m_inst  = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_if_pc = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
    if (chk_en) begin
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_if_pc", if_pc, m_if_pc);
      chk("model_if_inst", if_inst, m_inst);
      chk("model_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("model_fetch_count", fetch_count, m_cnt);
    end
  end

  // ---------------- driver ----------------
  // One edge with the given inputs; returns 2 time units after the edge.
  task automatic cyc(input logic r, input logic f, input logic b, input logic [W-1:0] a);
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset for two edges, then release
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    cyc(1, 0, 0, 0);
    chk("first_if_pc", if_pc, 32'h4);
    chk("first_if_inst", if_inst, 32'hFFFF0000);
    chk("first_if_valid", {31'd0, if_valid}, 32'd1);

    // 2. straight line: 5 free edges in total
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("line_imem_addr", imem_addr, 32'd20);
    chk("line_fetch_count", fetch_count, 32'd5);
    chk("line_if_pc", if_pc, 32'd20);
    chk("line_if_inst", if_inst, 32'hFFEF0010);

    // 3. freeze at imem_addr 12
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    chk("pre_frz_imem_addr", imem_addr, 32'd12);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0);
      chk("frz_imem_addr", imem_addr, 32'd12);
      chk("frz_if_pc", if_pc, 32'd12);
      chk("frz_if_inst", if_inst, 32'hFFF70008);
      chk("frz_fetch_count", fetch_count, 32'd3);
    end
    cyc(1, 0, 0, 0);
    chk("unfrz_imem_addr", imem_addr, 32'd16);
    chk("unfrz_if_inst", if_inst, 32'hFFF3000C);

    // 4. branch under freeze
    cyc(1, 1, 1, 32'h58);
    chk("brfrz_imem_addr", imem_addr, 32'h58);
    chk("brfrz_if_valid", {31'd0, if_valid}, 32'd0);
    chk("brfrz_if_inst", if_inst, 32'h0);
    chk("brfrz_fetch_count", fetch_count, 32'd4);
    cyc(1, 0, 0, 0);
    chk("postbr_if_pc", if_pc, 32'h5C);
    chk("postbr_if_inst", if_inst, 32'hFFA70058);
    chk("postbr_fetch_count", fetch_count, 32'd5);

    // 5. misaligned and wrapping targets
    cyc(1, 0, 1, 32'h93);
    chk("misal_imem_addr", imem_addr, 32'h90);
    cyc(1, 0, 1, 32'hFFFFFFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_imem_addr", imem_addr, 32'h0);
    chk("wrap_if_pc", if_pc, 32'h0);
    chk("wrap_if_inst", if_inst, 32'h0003FFFC);

    // branch held high: a bubble every cycle
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 32'h100 + 32'(i * 8));
      chk("hold_br_if_valid", {31'd0, if_valid}, 32'd0);
    end
    chk("hold_br_imem_addr", imem_addr, 32'h110);

    // 6. reset during freeze at pc 0x40
    cyc(1, 0, 1, 32'h40);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("midrst_imem_addr", imem_addr, 32'h0);
    chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_fetch_count", fetch_count, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, f, b;
      logic [W-1:0] a;
      r = ($urandom_range(0, 99) != 0);
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      a = $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      cyc(r, f, b, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
